uart_reg_bank: RTL and testbench

//  Parametrised register bank written/read over the byte interface of uart_core.

---
 rtl/uart_reg_bank_pkg.sv | 16 +
 rtl/uart_frame_timer.sv | 40 ++++
 rtl/uart_reg_bank.sv | 160 ++++++++++++++++
 tb/tb_uart_reg_bank.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_bank_pkg.sv
// Shared constants and state encoding for the UART register bank.
package uart_reg_bank_pkg;

    localparam logic [7:0] ACK_BYTE   = 8'hA5;
    localparam logic [7:0] ERR_BYTE   = 8'hEE;
    localparam int         CMD_WR_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_COMMIT,
        ST_TX_RESP,
        ST_TX_WAIT
    } state_e;

endpackage

// File: rtl/uart_frame_timer.sv
// Idle counter between bytes of one frame; flags when the gap reaches TIMEOUT_CYC.
module uart_frame_timer
    import uart_reg_bank_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter saturates at LIMIT so a long stall can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_reg_bank.sv
// Command-frame decoder and register array behind the uart_core byte interface.
module uart_reg_bank
    import uart_reg_bank_pkg::*;
#(
    parameter int                 W_REG       = 32,
    parameter int                 N_REGS      = 8,
    parameter logic [N_REGS-1:0]  RO_MASK     = '0,
    parameter logic [W_REG-1:0]   RST_VAL     = '0,
    parameter int                 TIMEOUT_CYC = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_valid,
    output logic [7:0]                tx_byte,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [N_REGS*W_REG-1:0]   regs_in,
    output logic [N_REGS*W_REG-1:0]   regs_out,
    output logic [N_REGS-1:0]         wr_strobe,
    output logic                      rx_drop
);

    localparam int NB     = W_REG / 8;
    localparam int ADDR_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int CNT_W  = $clog2(NB + 1);

    logic [W_REG-1:0]  regs_q [N_REGS];
    state_e            state_q;
    logic [6:0]        cmd_addr_q;
    logic [W_REG-1:0]  shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        tx_byte_q;
    logic              tx_valid_q;
    logic [N_REGS-1:0] wr_strobe_q;
    logic              rx_drop_q;

    logic              timeout;
    logic [ADDR_W-1:0] rx_idx;
    logic [ADDR_W-1:0] cmd_idx;
    logic              rx_addr_ok;
    logic              cmd_ok;
    logic [W_REG-1:0]  rd_val;
    logic [W_REG-1:0]  shift_in;
    logic [W_REG-1:0]  shift_nx;

    for (genvar i = 0; i < N_REGS; i++) begin : g_out
        assign regs_out[i*W_REG +: W_REG] = RO_MASK[i] ? regs_in[i*W_REG +: W_REG] : regs_q[i];
    end

    // Full 7-bit address is compared so out-of-range addresses never alias onto real registers.
    assign rx_idx     = rx_byte[ADDR_W-1:0];
    assign cmd_idx    = cmd_addr_q[ADDR_W-1:0];
    assign rx_addr_ok = ({1'b0, rx_byte[6:0]} < 8'(N_REGS));
    assign cmd_ok     = ({1'b0, cmd_addr_q} < 8'(N_REGS)) && !RO_MASK[cmd_idx];
    assign rd_val     = regs_out[rx_idx*W_REG +: W_REG];
    assign shift_nx   = shift_q >> 8;
    assign shift_in   = shift_nx | (W_REG'(rx_byte) << (W_REG - 8));

    uart_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (rx_valid),
        .en_i      (state_q == ST_RX_DATA),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_addr_q  <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            tx_byte_q   <= '0;
            tx_valid_q  <= 1'b0;
            wr_strobe_q <= '0;
            rx_drop_q   <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            wr_strobe_q <= '0;
            rx_drop_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        cmd_addr_q <= rx_byte[6:0];
                        if (rx_byte[CMD_WR_BIT]) begin
                            cnt_q   <= '0;
                            state_q <= ST_RX_DATA;
                        end else begin
                            // Reads snapshot the value now; later register changes do not leak in.
                            if (rx_addr_ok) begin
                                shift_q   <= rd_val;
                                tx_byte_q <= rd_val[7:0];
                                cnt_q     <= CNT_W'(NB - 1);
                            end else begin
                                tx_byte_q <= ERR_BYTE;
                                cnt_q     <= '0;
                            end
                            state_q <= ST_TX_RESP;
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (rx_valid) begin
                        shift_q <= shift_in;
                        if (cnt_q == CNT_W'(NB - 1)) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (timeout) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    rx_drop_q <= rx_valid;
                    if (cmd_ok) begin
                        regs_q[cmd_idx]      <= shift_q;
                        wr_strobe_q[cmd_idx] <= 1'b1;
                        tx_byte_q            <= ACK_BYTE;
                    end else begin
                        tx_byte_q <= ERR_BYTE;
                    end
                    cnt_q   <= '0;
                    state_q <= ST_TX_RESP;
                end
                ST_TX_RESP: begin
                    rx_drop_q <= rx_valid;
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                    end else if (tx_ready) begin
                        if (cnt_q == '0) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= ST_TX_WAIT;
                        end else begin
                            shift_q   <= shift_nx;
                            tx_byte_q <= shift_nx[7:0];
                            cnt_q     <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_TX_WAIT: begin
                    rx_drop_q <= rx_valid;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_byte   = tx_byte_q;
    assign tx_valid  = tx_valid_q;
    assign wr_strobe = wr_strobe_q;
    assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank with a frame-level model of the register bank.
module tb_uart_reg_bank;

    localparam logic [7:0] RO_TB = 8'h80;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready;
    logic [255:0] regs_in;
    logic [255:0] regs_out;
    logic [7:0]   wr_strobe;
    logic         rx_drop;

    always #5 clk = ~clk;

    uart_reg_bank #(
        .W_REG       (32),
        .N_REGS      (8),
        .RO_MASK     (8'h80),
        .RST_VAL     (32'h0),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .regs_in   (regs_in),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .rx_drop   (rx_drop)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_regs [8];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          exp_strobe [8];
    int          seen_strobe [8];
    int          exp_drop  = 0;
    int          seen_drop = 0;
    bit          check_en  = 1'b0;
    bit          stall_prev = 1'b0;
    logic [7:0]  prev_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, got, exp);
    endtask

    function automatic logic [31:0] model_val(input int a);
        return RO_TB[a] ? regs_in[a*32 +: 32] : m_regs[a];
    endfunction

    function automatic logic [255:0] exp_regs();
        logic [255:0] v;
        for (int a = 0; a < 8; a++) v[a*32 +: 32] = model_val(a);
        return v;
    endfunction

    function automatic logic [31:0] got_word();
        if (got_q.size() != 4) return 32'hxxxx_xxxx;
        return {got_q[3], got_q[2], got_q[1], got_q[0]};
    endfunction

    task automatic model_write(input logic [7:0] cmd, input logic [31:0] data);
        int a;
        a = int'(cmd[6:0]);
        if (a < 8 && !RO_TB[a]) begin
            m_regs[a] = data;
            exp_strobe[a]++;
            exp_q.push_back(8'hA5);
        end else begin
            exp_q.push_back(8'hEE);
        end
    endtask

    task automatic model_read(input logic [7:0] cmd);
        int a;
        logic [31:0] v;
        a = int'(cmd[6:0]);
        if (a < 8) begin
            v = model_val(a);
            for (int k = 0; k < 4; k++) exp_q.push_back(v[k*8 +: 8]);
        end else begin
            exp_q.push_back(8'hEE);
        end
    endtask

    // Single compare process: tx handshakes, hold stability, pulse counts, register contents.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_byte", 32'(tx_byte), 32'(prev_byte));
            end
            stall_prev = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got %02h while no response byte was due", tx_byte);
                end else begin
                    check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
                end
                got_q.push_back(tx_byte);
            end
            for (int i = 0; i < 8; i++) if (wr_strobe[i]) seen_strobe[i]++;
            if (rx_drop) seen_drop++;
            if (check_en) begin
                n_checks++;
                if (regs_out === exp_regs()) n_pass++;
                else $display("FAIL regs_out: got %h expected %h", regs_out, exp_regs());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        for (int i = 0; i < 8; i++) check($sformatf("strobe_count%0d", i), 32'(seen_strobe[i]), 32'(exp_strobe[i]));
        check("rx_drop_count", 32'(seen_drop), 32'(exp_drop));
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [31:0] data);
        check_en = 1'b0;
        got_q.delete();
        model_write(cmd, data);
        send_byte(cmd);
        for (int k = 0; k < 4; k++) send_byte(data[k*8 +: 8]);
        wait_done("write_done");
        check_en = 1'b1;
    endtask

    task automatic do_read(input logic [7:0] cmd);
        got_q.delete();
        model_read(cmd);
        send_byte(cmd);
        wait_done("read_done");
    endtask

    initial begin
        bit ok;
        rst      = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        regs_in  = '0;
        regs_in[7*32 +: 32] = 32'hCAFEF00D;
        regs_in[3*32 +: 32] = 32'hDEADBEEF;
        regs_in[1*32 +: 32] = 32'h0BADF00D;
        for (int i = 0; i < 8; i++) begin
            m_regs[i]      = 32'h0;
            exp_strobe[i]  = 0;
            seen_strobe[i] = 0;
        end

        repeat (3) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_rx_drop", 32'(rx_drop), 32'd0);
        check("rst_reg7_mirror", regs_out[7*32 +: 32], 32'hCAFEF00D);
        check("rst_reg3", regs_out[3*32 +: 32], 32'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        check_en = 1'b1;

        do_write(8'h83, 32'h12345678);
        check("wr3_value", regs_out[3*32 +: 32], 32'h12345678);
        check("wr3_ack", 32'(got_q.size() == 1 ? got_q[0] : 8'h00), 32'hA5);
        check_counts();

        // Read with the transmitter stalled; one byte arrives mid-response and must be dropped.
        got_q.delete();
        tx_ready = 1'b0;
        model_read(8'h03);
        send_byte(8'h03);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_tx_valid_seen", 32'(ok), 32'd1);
        send_byte(8'h55);
        exp_drop++;
        repeat (8) @(posedge clk);
        #1;
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_byte", 32'(tx_byte), 32'h78);
        tx_ready = 1'b1;
        wait_done("stall_read_done");
        check("rd3_word", got_word(), 32'h12345678);
        check_counts();

        do_write(8'h87, 32'h11223344);
        check("wr_ro_err", 32'(got_q.size() == 1 ? got_q[0] : 8'h00), 32'hEE);
        do_write(8'h8A, 32'h55667788);
        check("wr_bad_err", 32'(got_q.size() == 1 ? got_q[0] : 8'h00), 32'hEE);
        check_counts();

        do_read(8'h07);
        check("rd7_word", got_word(), 32'hCAFEF00D);
        do_read(8'h09);
        check("rd9_err", 32'(got_q.size() == 1 ? got_q[0] : 8'h00), 32'hEE);

        do_write(8'h80, 32'hA5A50F0F);
        do_read(8'h00);
        check("rd0_word", got_word(), 32'hA5A50F0F);

        // Partial write followed by a gap longer than the frame timeout.
        got_q.delete();
        send_byte(8'h81);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (60) @(posedge clk);
        #1;
        check("timeout_no_tx", 32'(got_q.size()), 32'd0);
        do_read(8'h01);
        check("rd1_after_abort", got_word(), 32'h0);
        check_counts();

        // Reset asserted while the third read byte is on the wire.
        got_q.delete();
        model_read(8'h03);
        send_byte(8'h03);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (tx_valid && tx_byte == 8'h34) begin
                ok = 1'b1;
                break;
            end
        end
        check("third_byte_seen", 32'(ok), 32'd1);
        rst      = 1'b1;
        check_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        @(negedge clk);
        check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mid_reg3", regs_out[3*32 +: 32], 32'h0);
        check("rst_mid_reg0", regs_out[0 +: 32], 32'h0);
        check("rst_mid_bytes", 32'(got_q.size()), 32'd2);
        @(posedge clk); #1;
        rst      = 1'b0;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_read(8'h03);
        check("rd3_after_rst", got_word(), 32'h0);
        check_counts();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
